load_store_unit: RTL and testbench

Data-memory access unit that consumes the MemRead/MemWrite/Funct3 controls produced by instruction decode and executes them as bus transactions. Takes the ALU-computed address and rs2 store data, and drives a single-outstanding valid/ready memory bus with byte strobes. Returns aligned, sign- or zero-extended load data to writeback. Stalls the single-cycle core while a bus access is in flight.

---
 rtl/load_store_unit.sv | 185 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Data-memory access unit. Turns decoded load/store controls into a single
// outstanding valid/ready bus access and returns extended load data.
//
// Ports:
//   clk, rst                  core clock, asynchronous active-high reset
//   MemRead, MemWrite, Funct3 decoded access request (store wins if both set)
//   Addr, StoreData           effective byte address and rs2 store value
//   Stall                     core holds PC/decode inputs while high
//   LoadData, LoadValid       extended load result and its one-cycle strobe
//   Fault                     one-cycle pulse for an illegal/misaligned access
//   BusAddr, BusWData,
//   BusWStrb, BusWe,
//   BusValid                  memory request channel
//   BusReady, BusRData        memory handshake and read data
module load_store_unit #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [2:0]            Funct3,
    input  logic [ADDR_WIDTH-1:0] Addr,
    input  logic [DATA_WIDTH-1:0] StoreData,
    output logic                  Stall,
    output logic [DATA_WIDTH-1:0] LoadData,
    output logic                  LoadValid,
    output logic                  Fault,
    output logic [ADDR_WIDTH-1:0] BusAddr,
    output logic [DATA_WIDTH-1:0] BusWData,
    output logic [3:0]            BusWStrb,
    output logic                  BusWe,
    output logic                  BusValid,
    input  logic                  BusReady,
    input  logic [DATA_WIDTH-1:0] BusRData
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   bus_addr_q, bus_addr_d;
    logic [DATA_WIDTH-1:0]   bus_wdata_q, bus_wdata_d;
    logic [STRB_W-1:0]       bus_wstrb_q, bus_wstrb_d;
    logic                    bus_we_q, bus_we_d;
    logic [2:0]              funct3_q, funct3_d;
    logic [1:0]              off_q, off_d;
    logic [DATA_WIDTH-1:0]   load_data_q, load_data_d;

    logic                    req;
    logic                    legal;
    logic                    aligned;
    logic                    accept;
    logic [STRB_W-1:0]       strb_c;
    logic [DATA_WIDTH-1:0]   wdata_c;
    logic [DATA_WIDTH-1:0]   shifted;
    logic                    sgn;
    logic [DATA_WIDTH-1:0]   load_ext;

    // Request decode: legality, alignment and acceptance in IDLE
    always_comb begin
        req   = MemRead | MemWrite;
        legal = 1'b0;
        if (MemWrite) begin
            legal = (Funct3 == 3'b000) || (Funct3 == 3'b001) || (Funct3 == 3'b010);
        end else begin
            legal = (Funct3 == 3'b000) || (Funct3 == 3'b001) || (Funct3 == 3'b010) ||
                    (Funct3 == 3'b100) || (Funct3 == 3'b101);
        end
        case (Funct3[1:0])
            2'b01:   aligned = ~Addr[0];
            2'b10:   aligned = (Addr[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
        accept = ~rst && (state_q == S_IDLE) && req && legal && aligned;
    end

    // Store lane placement: strobe shifted to the byte offset, data replicated
    always_comb begin
        strb_c  = '0;
        wdata_c = '0;
        if (MemWrite) begin
            case (Funct3[1:0])
                2'b00: begin
                    strb_c  = STRB_W'(4'b0001 << Addr[1:0]);
                    wdata_c = {4{StoreData[7:0]}};
                end
                2'b01: begin
                    strb_c  = STRB_W'(4'b0011 << Addr[1:0]);
                    wdata_c = {2{StoreData[15:0]}};
                end
                default: begin
                    strb_c  = '1;
                    wdata_c = StoreData;
                end
            endcase
        end
    end

    // Load extraction from the latched offset and size
    always_comb begin
        shifted = BusRData >> {off_q, 3'b000};
        sgn     = ~funct3_q[2];
        case (funct3_q[1:0])
            2'b00:   load_ext = {{24{sgn & shifted[7]}}, shifted[7:0]};
            2'b01:   load_ext = {{16{sgn & shifted[15]}}, shifted[15:0]};
            default: load_ext = BusRData;
        endcase
    end

    // Next-state and latched transaction fields
    always_comb begin
        state_d     = state_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_wstrb_d = bus_wstrb_q;
        bus_we_d    = bus_we_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        load_data_d = load_data_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    bus_addr_d  = {Addr[ADDR_WIDTH-1:2], 2'b00};
                    bus_wdata_d = wdata_c;
                    bus_wstrb_d = strb_c;
                    bus_we_d    = MemWrite;
                    funct3_d    = Funct3;
                    off_d       = Addr[1:0];
                    state_d     = S_REQ;
                end
            end
            S_REQ: begin
                if (BusReady) begin
                    if (!bus_we_q) begin
                        load_data_d = load_ext;
                    end
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_wstrb_q <= '0;
            bus_we_q    <= 1'b0;
            funct3_q    <= 3'b000;
            off_q       <= 2'b00;
            load_data_q <= '0;
        end else begin
            state_q     <= state_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_wstrb_q <= bus_wstrb_d;
            bus_we_q    <= bus_we_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            load_data_q <= load_data_d;
        end
    end

    // Stall/Fault respond in the request cycle so the core freezes immediately
    assign Stall     = accept | (state_q == S_REQ);
    assign Fault     = ~rst && (state_q == S_IDLE) && req && !(legal && aligned);
    assign LoadValid = (state_q == S_DONE) && !bus_we_q;
    assign BusValid  = (state_q == S_REQ);
    assign BusAddr   = bus_addr_q;
    assign BusWData  = bus_wdata_q;
    assign BusWStrb  = bus_wstrb_q;
    assign BusWe     = bus_we_q;
    assign LoadData  = load_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random
// accesses checked against a byte-level reference model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead, MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] Addr, StoreData;
    logic        Stall, LoadValid, Fault;
    logic [31:0] LoadData;
    logic [31:0] BusAddr, BusWData;
    logic [3:0]  BusWStrb;
    logic        BusWe, BusValid, BusReady;
    logic [31:0] BusRData;

    int          passed = 0;
    int          total  = 0;
    logic [31:0] exp_ld = 32'h0;

    load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .MemRead(MemRead), .MemWrite(MemWrite), .Funct3(Funct3),
        .Addr(Addr), .StoreData(StoreData),
        .Stall(Stall), .LoadData(LoadData), .LoadValid(LoadValid), .Fault(Fault),
        .BusAddr(BusAddr), .BusWData(BusWData), .BusWStrb(BusWStrb),
        .BusWe(BusWe), .BusValid(BusValid),
        .BusReady(BusReady), .BusRData(BusRData)
    );

    always #5 clk = ~clk;

    // One full access: request cycle, REQ cycles with `delay` not-ready cycles, DONE, back to IDLE
    task automatic do_access(input bit rd, input bit wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] sdata,
                             input logic [31:0] rdata, input int delay, input string tag);
        bit          st, legal, al;
        int          nb, off;
        logic [3:0]  e_strb;
        logic [31:0] e_wd, e_ld;
        longint      v;
        st    = wr;
        legal = st ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        nb    = 1 << f3[1:0];
        off   = int'(addr[1:0]);
        al    = (int'(addr % 32'(nb)) == 0);
        e_strb = st ? 4'(((1 << nb) - 1) << off) : 4'b0000;
        for (int i = 0; i < 4; i++) e_wd[8*i +: 8] = st ? sdata[8*(i % nb) +: 8] : 8'h00;
        v = longint'(rdata >> (8 * off));
        if (nb < 4) begin
            v = v & ((64'sd1 << (8 * nb)) - 1);
            if (!f3[2] && v >= (64'sd1 << (8 * nb - 1))) v = v - (64'sd1 << (8 * nb));
        end else begin
            v = longint'(rdata);
        end
        e_ld = 32'(v);

        @(negedge clk);
        MemRead = rd; MemWrite = wr; Funct3 = f3; Addr = addr; StoreData = sdata;
        BusReady = (delay == 0); BusRData = $urandom;
        #1;
        if (!(legal && al)) begin
            total++;
            if ({Fault, Stall, BusValid, LoadValid} !== 4'b1000)
                $display("FAIL %s fault_cycle {Fault,Stall,BusValid,LoadValid} got %b want 1000", tag,
                         {Fault, Stall, BusValid, LoadValid});
            else passed++;
            @(posedge clk); @(negedge clk);
            MemRead = 1'b0; MemWrite = 1'b0; #1;
            total++;
            if ({Fault, Stall, BusValid, LoadValid} !== 4'b0000 || LoadData !== exp_ld)
                $display("FAIL %s after_fault flags %b LoadData %h want 0000 %h", tag,
                         {Fault, Stall, BusValid, LoadValid}, LoadData, exp_ld);
            else passed++;
            return;
        end
        total++;
        if ({Fault, Stall, BusValid, LoadValid} !== 4'b0100)
            $display("FAIL %s request_cycle {Fault,Stall,BusValid,LoadValid} got %b want 0100", tag,
                     {Fault, Stall, BusValid, LoadValid});
        else passed++;

        for (int k = 0; k <= delay; k++) begin
            @(posedge clk); @(negedge clk);
            BusReady = (k >= delay); BusRData = rdata; #1;
            total++;
            if ({BusValid, Stall, LoadValid, Fault, BusWe, BusWStrb} !== {4'b1100, st, e_strb})
                $display("FAIL %s req%0d ctl got %b want %b", tag, k,
                         {BusValid, Stall, LoadValid, Fault, BusWe, BusWStrb}, {4'b1100, st, e_strb});
            else passed++;
            total++;
            if (BusAddr !== {addr[31:2], 2'b00} || BusWData !== e_wd)
                $display("FAIL %s req%0d addr/wdata got %h/%h want %h/%h", tag, k,
                         BusAddr, BusWData, {addr[31:2], 2'b00}, e_wd);
            else passed++;
        end

        @(posedge clk); @(negedge clk); #1;
        if (!st) exp_ld = e_ld;
        total++;
        if ({BusValid, Stall, Fault, LoadValid} !== {3'b000, !st} || LoadData !== exp_ld)
            $display("FAIL %s done flags %b LoadData %h want %b %h", tag,
                     {BusValid, Stall, Fault, LoadValid}, LoadData, {3'b000, !st}, exp_ld);
        else passed++;

        @(posedge clk); @(negedge clk);
        MemRead = 1'b0; MemWrite = 1'b0; BusReady = 1'b0; #1;
        total++;
        if ({BusValid, Stall, LoadValid} !== 3'b000 || LoadData !== exp_ld)
            $display("FAIL %s idle flags %b LoadData %h want 000 %h", tag,
                     {BusValid, Stall, LoadValid}, LoadData, exp_ld);
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; Funct3 = 3'b000;
        Addr = 32'h0; StoreData = 32'h0; BusReady = 1'b0; BusRData = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if ({Stall, LoadValid, Fault, BusValid, BusWe, BusWStrb} !== 9'b0 ||
            BusAddr !== 32'h0 || BusWData !== 32'h0 || LoadData !== 32'h0)
            $display("FAIL reset_values got flags %b addr %h wdata %h ld %h want all zero",
                     {Stall, LoadValid, Fault, BusValid, BusWe, BusWStrb}, BusAddr, BusWData, LoadData);
        else passed++;
        rst = 1'b0;
        exp_ld = 32'h0;
    endtask

    task automatic test_loads();
        do_access(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, "lw_100");
        do_access(1, 0, 3'b000, 32'h203, 32'h0, 32'h80112233, 0, "lb_203");
        do_access(1, 0, 3'b100, 32'h203, 32'h0, 32'h80112233, 0, "lbu_203");
        do_access(1, 0, 3'b101, 32'h202, 32'h0, 32'h80112233, 0, "lhu_202");
        do_access(1, 0, 3'b001, 32'h202, 32'h0, 32'h80112233, 1, "lh_202");
    endtask

    task automatic test_stores();
        do_access(0, 1, 3'b001, 32'h302, 32'h1234ABCD, 32'h0, 0, "sh_302");
        do_access(0, 1, 3'b000, 32'h301, 32'h1234ABCD, 32'h0, 0, "sb_301");
        do_access(1, 1, 3'b010, 32'h40, 32'hCAFEF00D, 32'h0, 3, "sw_40_wait3");
    endtask

    task automatic test_faults();
        do_access(1, 0, 3'b010, 32'h101, 32'h0, 32'h0, 0, "lw_misaligned");
        do_access(0, 1, 3'b001, 32'h103, 32'h55, 32'h0, 0, "sh_misaligned");
        do_access(1, 0, 3'b011, 32'h100, 32'h0, 32'h0, 0, "load_f3_011");
        do_access(0, 1, 3'b100, 32'h100, 32'h0, 32'h0, 0, "store_f3_100");
    endtask

    task automatic test_reset_mid_req();
        @(negedge clk);
        MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010; Addr = 32'h80; BusReady = 1'b0;
        @(posedge clk); @(negedge clk); #1;
        total++;
        if (BusValid !== 1'b1)
            $display("FAIL rst_mid_req pre BusValid got %b want 1", BusValid);
        else passed++;
        rst = 1'b1; #1;
        exp_ld = 32'h0;
        total++;
        if ({BusValid, Stall, LoadValid, Fault} !== 4'b0000 || LoadData !== 32'h0)
            $display("FAIL rst_mid_req during flags %b ld %h want 0000 0", {BusValid, Stall, LoadValid, Fault}, LoadData);
        else passed++;
        @(posedge clk); @(negedge clk);
        rst = 1'b0; MemRead = 1'b0; BusReady = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); @(negedge clk); #1;
            total++;
            if ({BusValid, Stall, LoadValid} !== 3'b000)
                $display("FAIL rst_mid_req after%0d flags %b want 000", k, {BusValid, Stall, LoadValid});
            else passed++;
        end
        do_access(1, 0, 3'b010, 32'h84, 32'h0, 32'h13579BDF, 0, "lw_after_rst");
    endtask

    task automatic test_random();
        int          kind;
        logic [31:0] a;
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 2);
            a    = $urandom;
            do_access(kind != 1, kind != 0, 3'($urandom_range(0, 7)), a, $urandom, $urandom,
                      $urandom_range(0, 2), $sformatf("rand%0d", n));
        end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_stores();
        test_faults();
        test_reset_mid_req();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
